// File: rtl/plot_port_arbiter.sv
// plot_port_arbiter: shares the single vga_adapter write port between
// NUM_REQ round-robin pixel requesters and a full-screen clear engine.
// The clear sweep has absolute priority over the requesters.
module plot_port_arbiter #(
  parameter int unsigned NUM_REQ      = 2,
  parameter int unsigned X_MAX        = 159,
  parameter int unsigned Y_MAX        = 119,
  parameter logic [2:0]  CLEAR_COLOUR = 3'b000
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [8*NUM_REQ-1:0]   req_x,
  input  logic [7*NUM_REQ-1:0]   req_y,
  input  logic [3*NUM_REQ-1:0]   req_colour,
  output logic [NUM_REQ-1:0]     grant,
  input  logic                   clear_start,
  output logic                   clear_busy,
  output logic [7:0]             x_out,
  output logic [6:0]             y_out,
  output logic [2:0]             colour_out,
  output logic                   plot
);

  localparam int unsigned PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [7:0]  XM = X_MAX[7:0];
  localparam logic [6:0]  YM = Y_MAX[6:0];

  typedef enum logic {S_IDLE, S_CLEAR} state_t;

  state_t               state_q, state_d;
  logic [PW-1:0]        ptr_q, ptr_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic                 plot_q, plot_d;
  logic [7:0]           x_q, x_d;
  logic [6:0]           y_q, y_d;
  logic [2:0]           colour_q, colour_d;
  logic                 busy_q, busy_d;
  logic [7:0]           sx_q, sx_d;
  logic [6:0]           sy_q, sy_d;

  logic [NUM_REQ-1:0]   eligible;
  logic                 win_found;
  logic [NUM_REQ-1:0]   win_oh;
  logic [7:0]           win_x;
  logic [6:0]           win_y;
  logic [2:0]           win_colour;
  logic [PW-1:0]        win_ptr;

  // Round-robin pick: first eligible index at or after the pointer, wrapping.
  // Two passes (at/after pointer, then from 0) avoid a variable-width modulo.
  always_comb begin
    eligible   = req & ~grant_q;
    win_found  = 1'b0;
    win_oh     = '0;
    win_x      = '0;
    win_y      = '0;
    win_colour = '0;
    win_ptr    = '0;
    for (int unsigned pass = 0; pass < 2; pass++) begin
      for (int unsigned j = 0; j < NUM_REQ; j++) begin
        if (!win_found && eligible[j] && (pass == 1 || j >= 32'(ptr_q))) begin
          win_found  = 1'b1;
          win_oh[j]  = 1'b1;
          win_x      = req_x[8*j +: 8];
          win_y      = req_y[7*j +: 7];
          win_colour = req_colour[3*j +: 3];
          win_ptr    = (j == NUM_REQ - 1) ? '0 : PW'(j + 1);
        end
      end
    end
  end

  // Next-state and registered-output computation for both modes.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    grant_d  = '0;
    plot_d   = 1'b0;
    x_d      = x_q;
    y_d      = y_q;
    colour_d = colour_q;
    busy_d   = busy_q;
    sx_d     = sx_q;
    sy_d     = sy_q;
    case (state_q)
      S_IDLE: begin
        busy_d = 1'b0;
        if (clear_start) begin
          state_d  = S_CLEAR;
          busy_d   = 1'b1;
          plot_d   = 1'b1;
          sx_d     = '0;
          sy_d     = '0;
          x_d      = '0;
          y_d      = '0;
          colour_d = CLEAR_COLOUR;
        end else if (win_found) begin
          grant_d  = win_oh;
          x_d      = win_x;
          y_d      = win_y;
          colour_d = win_colour;
          // Out-of-range pixels are consumed but not drawn.
          plot_d   = (win_x <= XM) && (win_y <= YM);
          ptr_d    = win_ptr;
        end
      end
      S_CLEAR: begin
        // sx/sy hold the pixel currently presented on the outputs.
        if (sx_q == XM && sy_q == YM) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
          sx_d    = '0;
          sy_d    = '0;
        end else begin
          if (sx_q == XM) begin
            sx_d = '0;
            sy_d = sy_q + 7'd1;
          end else begin
            sx_d = sx_q + 8'd1;
          end
          busy_d   = 1'b1;
          plot_d   = 1'b1;
          x_d      = sx_d;
          y_d      = sy_d;
          colour_d = CLEAR_COLOUR;
        end
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State, pointer, sweep counters and all outputs registered here.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      ptr_q    <= '0;
      grant_q  <= '0;
      plot_q   <= 1'b0;
      x_q      <= '0;
      y_q      <= '0;
      colour_q <= '0;
      busy_q   <= 1'b0;
      sx_q     <= '0;
      sy_q     <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      grant_q  <= grant_d;
      plot_q   <= plot_d;
      x_q      <= x_d;
      y_q      <= y_d;
      colour_q <= colour_d;
      busy_q   <= busy_d;
      sx_q     <= sx_d;
      sy_q     <= sy_d;
    end
  end

  assign grant      = grant_q;
  assign plot       = plot_q;
  assign x_out      = x_q;
  assign y_out      = y_q;
  assign colour_out = colour_q;
  assign clear_busy = busy_q;

endmodule

// File: tb/tb_plot_port_arbiter.sv
// Scoreboard bench for plot_port_arbiter: stimulus pushes expected grants,
// a negedge monitor pops/compares them and accumulates clear-sweep pixels.
module tb_plot_port_arbiter;

  localparam int unsigned N = 2;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic [N-1:0]   req = '0;
  logic [8*N-1:0] req_x = '0;
  logic [7*N-1:0] req_y = '0;
  logic [3*N-1:0] req_colour = '0;
  logic [N-1:0]   grant;
  logic           clear_start = 1'b0;
  logic           clear_busy;
  logic [7:0]     x_out;
  logic [6:0]     y_out;
  logic [2:0]     colour_out;
  logic           plot;

  plot_port_arbiter #(
    .NUM_REQ(N), .X_MAX(159), .Y_MAX(119), .CLEAR_COLOUR(3'b000)
  ) dut (
    .clk(clk), .reset(reset), .req(req), .req_x(req_x), .req_y(req_y),
    .req_colour(req_colour), .grant(grant), .clear_start(clear_start),
    .clear_busy(clear_busy), .x_out(x_out), .y_out(y_out),
    .colour_out(colour_out), .plot(plot)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] g;
    logic         p;
    logic [7:0]   x;
    logic [6:0]   y;
    logic [2:0]   c;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;
  int   vectors = 0;
  int   miscompares = 0;

  // Clear-sweep accumulators, written by the monitor.
  int         pix_cnt = 0;
  int         bad_cnt = 0;
  logic [2:0] hash = '0;
  logic [7:0] cp_x [3];
  logic [6:0] cp_y [3];
  logic [7:0] last_x = '0;
  logic [6:0] last_y = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    vectors++;
    if (act !== want) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, act, want);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input int x, input int y, input int c);
    logic [31:0] xv, yv, cv;
    xv = x; yv = y; cv = c;
    req_x[8*i +: 8]      = xv[7:0];
    req_y[7*i +: 7]      = yv[6:0];
    req_colour[3*i +: 3] = cv[2:0];
  endtask

  task automatic push_exp(input logic [N-1:0] g, input logic p, input int x, input int y, input int c);
    exp_t e;
    logic [31:0] xv, yv, cv;
    xv = x; yv = y; cv = c;
    e.g = g; e.p = p; e.x = xv[7:0]; e.y = yv[6:0]; e.c = cv[2:0];
    sbq.push_back(e);
  endtask

  task automatic clear_acc();
    pix_cnt = 0; bad_cnt = 0; hash = '0;
    for (int i = 0; i < 3; i++) begin cp_x[i] = '1; cp_y[i] = '1; end
  endtask

  function automatic logic [2:0] exp_hash();
    logic [2:0]  h;
    logic [31:0] xv, yv;
    h = '0;
    for (int y = 0; y < 120; y++) begin
      for (int x = 0; x < 160; x++) begin
        xv = x; yv = y;
        h = {h[1:0], h[2]} ^ xv[2:0] ^ yv[2:0] ^ 3'b000;
      end
    end
    return h;
  endfunction

  task automatic wait_clear_done();
    int n;
    n = 0;
    while (clear_busy === 1'b1 && n < 25000) begin
      step();
      n++;
    end
    if (clear_busy !== 1'b0) check("clear_timeout", clear_busy, 0);
  endtask

  task automatic check_sweep();
    check("sweep_len", pix_cnt, 19200);
    check("sweep_bad_pixels", bad_cnt, 0);
    check("first_x", cp_x[0], 0);    check("first_y", cp_y[0], 0);
    check("p159_x", cp_x[1], 159);   check("p159_y", cp_y[1], 0);
    check("p160_x", cp_x[2], 0);     check("p160_y", cp_y[2], 1);
    check("last_x", last_x, 159);    check("last_y", last_y, 119);
    check("sweep_hash", hash, exp_hash());
  endtask

  // Monitor: grant pulses are scoreboard transactions; busy cycles are sweep pixels.
  always @(negedge clk) begin
    if (grant != '0) begin
      if (sbq.size() == 0) begin
        check("unexpected_grant", grant, 0);
      end else begin
        mon_e = sbq.pop_front();
        check("grant", grant, mon_e.g);
        check("grant_plot", plot, mon_e.p);
        if (mon_e.p) begin
          check("grant_x", x_out, mon_e.x);
          check("grant_y", y_out, mon_e.y);
          check("grant_colour", colour_out, mon_e.c);
        end
      end
    end else if (plot === 1'b1 && clear_busy !== 1'b1) begin
      check("stray_plot", plot, 0);
    end
    if (clear_busy === 1'b1) begin
      if (plot !== 1'b1 || colour_out !== 3'b000 || grant !== '0) bad_cnt++;
      hash = {hash[1:0], hash[2]} ^ x_out[2:0] ^ y_out[2:0] ^ colour_out;
      if (pix_cnt == 0)   begin cp_x[0] = x_out; cp_y[0] = y_out; end
      if (pix_cnt == 159) begin cp_x[1] = x_out; cp_y[1] = y_out; end
      if (pix_cnt == 160) begin cp_x[2] = x_out; cp_y[2] = y_out; end
      last_x = x_out;
      last_y = y_out;
      pix_cnt++;
    end
  end

  initial begin
    clear_acc();
    step(); step();
    check("rst_grant", grant, 0);
    check("rst_plot", plot, 0);
    check("rst_x", x_out, 0);
    check("rst_y", y_out, 0);
    check("rst_colour", colour_out, 0);
    check("rst_busy", clear_busy, 0);
    reset = 1'b0;

    // Single request: one-cycle latency, then idle with held coordinates.
    set_req(0, 10, 60, 4); req = 2'b01;
    push_exp(2'b01, 1'b1, 10, 60, 4);
    step(); req = 2'b00;
    step();
    check("idle_plot", plot, 0);
    check("idle_grant", grant, 0);
    check("idle_hold_x", x_out, 10);

    // Fresh pointer, both requesters held: grants alternate.
    reset = 1'b1; step(); reset = 1'b0;
    set_req(0, 1, 2, 1); set_req(1, 3, 4, 2); req = 2'b11;
    for (int i = 0; i < 3; i++) begin
      push_exp(2'b01, 1'b1, 1, 2, 1);
      push_exp(2'b10, 1'b1, 3, 4, 2);
    end
    for (int i = 0; i < 6; i++) begin
      step();
      check("rr_plot_held", plot, 1);
    end
    req = 2'b00;
    step();
    check("rr_after_plot", plot, 0);

    // Out-of-range requests are granted but not plotted; boundaries in range.
    set_req(1, 200, 5, 7); req = 2'b10;
    push_exp(2'b10, 1'b0, 200, 5, 7);
    step(); req = 2'b00;
    check("oor_x_plot", plot, 0);
    set_req(0, 159, 119, 3); req = 2'b01;
    push_exp(2'b01, 1'b1, 159, 119, 3);
    step(); req = 2'b00;
    set_req(1, 160, 0, 6); req = 2'b10;
    push_exp(2'b10, 1'b0, 160, 0, 6);
    step(); req = 2'b00;
    set_req(0, 0, 120, 5); req = 2'b01;
    push_exp(2'b01, 1'b0, 0, 120, 5);
    step(); req = 2'b00;
    step();

    // Full clear sweep.
    clear_acc();
    clear_start = 1'b1; step(); clear_start = 1'b0;
    check("clear_busy_rise", clear_busy, 1);
    wait_clear_done();
    check("clear_end_plot", plot, 0);
    check_sweep();

    // Clear beats a simultaneous request; a second clear_start is ignored.
    clear_acc();
    set_req(1, 77, 33, 5); req = 2'b10;
    clear_start = 1'b1; step(); clear_start = 1'b0;
    check("clear_wins_grant", grant, 0);
    repeat (3000) step();
    clear_start = 1'b1; step(); clear_start = 1'b0;
    wait_clear_done();
    check("post_clear_c1_grant", grant, 0);
    push_exp(2'b10, 1'b1, 77, 33, 5);
    step();
    check("post_clear_c2_grant", grant, 2);
    req = 2'b00;
    step();
    check_sweep();

    // Move pointer to 1, then abort a clear at pixel 5000 with reset.
    set_req(0, 20, 21, 1); req = 2'b01;
    push_exp(2'b01, 1'b1, 20, 21, 1);
    step(); req = 2'b00;
    step();
    clear_acc();
    clear_start = 1'b1; step(); clear_start = 1'b0;
    repeat (5000) step();
    check("pix5000_x", x_out, 40);
    check("pix5000_y", y_out, 31);
    reset = 1'b1;
    step();
    check("abort_plot", plot, 0);
    check("abort_busy", clear_busy, 0);
    check("abort_grant", grant, 0);
    check("abort_pix_cnt", pix_cnt, 5001);
    reset = 1'b0;
    set_req(0, 30, 31, 2); set_req(1, 40, 41, 3); req = 2'b11;
    push_exp(2'b01, 1'b1, 30, 31, 2);
    push_exp(2'b10, 1'b1, 40, 41, 3);
    step();
    check("post_reset_first", grant, 1);
    step(); req = 2'b00;
    step(); step();
    check("sb_drained", sbq.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/plot_port_arbiter.md
Name: plot_port_arbiter

Overview:
- Shares the single vga_adapter write port (x, y, colour, plot) among NUM_REQ pixel requesters, e.g. the per-player light-cycle datapaths, and a built-in full-screen clear engine.
- Sits between the game datapaths/controls and the one vga_adapter instance in the top level.
- Arbitration between requesters is round-robin with a request/grant handshake. The clear sweep has absolute priority.

Parameters:
- NUM_REQ, 2, number of pixel requesters (2..4)
- X_MAX, 159, last valid x coordinate (160x120 mode)
- Y_MAX, 119, last valid y coordinate
- CLEAR_COLOUR, 3'b000, colour written by the clear sweep

Ports:
- clk  input  1  system clock (CLOCK_50 at top level)
- reset  input  1  synchronous, active-high reset
- req  input  NUM_REQ  per-requester pixel request; held high until granted
- req_x  input  8*NUM_REQ  x coordinate; requester i uses bits [8i+7:8i]
- req_y  input  7*NUM_REQ  y coordinate; requester i uses bits [7i+6:7i]
- req_colour  input  3*NUM_REQ  colour; requester i uses bits [3i+2:3i]
- grant  output  NUM_REQ  one-hot, one-cycle pulse: request i consumed
- clear_start  input  1  single-cycle pulse: start a full-screen clear
- clear_busy  output  1  high while the clear sweep is running
- x_out  output  8  to vga_adapter x
- y_out  output  7  to vga_adapter y
- colour_out  output  3  to vga_adapter colour
- plot  output  1  to vga_adapter plot

Behaviour:
- All outputs are registered.
- Reset values: grant=0, plot=0, x_out=0, y_out=0, colour_out=0, clear_busy=0. The round-robin pointer resets to 0, so requester 0 has top priority. The state resets to S_IDLE.
- Reset asserted mid-clear aborts the sweep immediately. The next cycle shows plot=0 and clear_busy=0.
- States:
  - S_IDLE: arbitrating.
  - S_CLEAR: sweeping.
- S_IDLE arbitration:
  - At edge N, eligible = req & ~grant. The requester granted in the current cycle is masked, because it cannot drop req until it sees grant.
  - The winner is the first eligible index at or after the pointer, in modulo-NUM_REQ order.
  - In cycle N+1: grant[winner]=1, x_out/y_out/colour_out = the winner's captured values, plot=1, pointer = winner+1 mod NUM_REQ.
  - Latency from req sampled to plot is 1 cycle. Requesters drop or change req in the cycle grant is seen.
  - If nothing is eligible: grant=0, plot=0, and x_out/y_out/colour_out hold their last values.
- Out-of-range request (x>X_MAX or y>Y_MAX): still granted, so it is consumed, but plot=0 that cycle. The pixel is dropped and no wrap occurs.
- Two requesters held continuously: grants alternate every cycle, and plot stays 1 every cycle.
- clear_start, sampled in S_IDLE:
  - Enter S_CLEAR. Next cycle: clear_busy=1, grant=0.
  - Sweep x 0..X_MAX as the inner loop and y 0..Y_MAX as the outer loop, one pixel per cycle with plot=1 and colour_out=CLEAR_COLOUR.
  - The first pixel (0,0) appears in the cycle after clear_start. The last pixel (X_MAX,Y_MAX) appears (X_MAX+1)*(Y_MAX+1) cycles later; this is 19200 cycles with the defaults.
  - clear_busy is high exactly during those 19200 pixel cycles. The following cycle shows clear_busy=0, plot=0, and the FSM is back in S_IDLE. Arbitration resumes on that cycle's edge.
- clear_start and req in the same cycle: the clear wins, no grant is issued, and req stays pending until after the clear.
- clear_start while in S_CLEAR: ignored. The sweep does not restart.
- Requests during S_CLEAR receive no grant. The round-robin pointer is unchanged by the clear.
- Sweep counters use widths of 8 bits (x) and 7 bits (y). They reset to 0 at sweep end, not by natural overflow.

Test Plan:
- Reset, then req=2'b01 with x=10, y=60, colour=3'b100 → the next cycle shows grant=2'b01, plot=1, x_out=10, y_out=60, colour_out=3'b100. The cycle after shows plot=0 once req drops.
- req=2'b11 held high for 6 cycles with distinct coordinates → grants run 01,10,01,10,01,10 and plot=1 on every cycle.
- req[1] with x=200, y=5 → grant=2'b10 and plot=0 that cycle. The next request is served normally.
- clear_start pulse → clear_busy=1 for exactly 19200 cycles. The bench checks plots (0,0) first, (159,0), (0,1), and (159,119) last, all with colour 000, and checks a 3-bit hash over every pixel.
- clear_start in the same cycle as req=2'b10 → no grant during the clear, then grant=2'b10 in the 2nd cycle after clear_busy falls. A second clear_start mid-sweep leaves the total sweep length unchanged.
- reset asserted at pixel 5000 of a clear → the next cycle shows plot=0, clear_busy=0, grant=0. A fresh req=2'b11 is then granted to requester 0 first.
